uart_link: RTL and testbench
============================

Name:
uart_link

Overview:
- Parameterised UART transmitter plus receiver pair sharing one clock and reset.
- TX serialises a parallel word into an 8N1-style frame: start bit, DATA_SIZE data bits, one stop bit.
- RX deserialises such a frame from a serial line and reports the word with a one-cycle completion strobe.
- Sits between on-chip logic and the board serial pins; also used in loopback (tx_out tied to rx_in) for self-test.

Parameters:
- FREQ, 50000000: clock frequency in Hz.
- BAUD, 115200: line bit rate.
- DATA_SIZE, 8: data bits per frame, 1..16.
- DIV (localparam): FREQ/BAUD, integer-truncated, clock cycles per bit. Must be >= 4; elaboration-time error otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_start  in  1  request to send tx_data; sampled on the rising clk edge.
- tx_data  in  DATA_SIZE  word to transmit; captured when tx_start is accepted.
- tx_out  out  1  serial output; idle high.
- tx_busy  out  1  high while a frame is in progress.
- rx_in  in  1  serial input; idle high.
- rx_data  out  DATA_SIZE  last correctly received word.
- rx_is_receiving  out  1  high from start-bit detection until the stop-bit sample.
- rx_is_completed  out  1  one-cycle strobe when rx_data is updated.

Behaviour:
- Reset (async): tx_out=1, tx_busy=0, rx_data=0, rx_is_receiving=0, rx_is_completed=0. Both FSMs go to IDLE. Reset mid-frame aborts the frame immediately.
- Frame format: start=0, data LSB first, stop=1. Each bit is exactly DIV cycles.
- TX FSM: IDLE -> START -> DATA(bit index 0..DATA_SIZE-1) -> STOP -> IDLE.
- TX accept: in IDLE, tx_start=1 at a clk edge latches tx_data into a shift register.
  - tx_out goes 0 and tx_busy goes 1 from that edge; registered outputs, no combinational path.
- tx_start while busy is ignored; the frame in flight is unaffected.
- tx_start held high continuously: next frame starts on the first edge after returning to IDLE, giving back-to-back frames.
- TX frame length: (DATA_SIZE+2)*DIV cycles. tx_busy falls at the end of the stop bit. tx_out is glitch-free.
- RX input: rx_in passes a 2-flop synchronizer; all RX timing is relative to the synchronized signal.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- RX start detection: in IDLE, synchronized line low enters START and sets rx_is_receiving.
- RX start check: after DIV/2 cycles (mid start bit), the line is re-sampled.
  - If high: false start; return to IDLE, drop rx_is_receiving, no strobe.
- RX data sampling: each data bit is sampled DIV cycles after the previous sample (mid-bit) and shifted in LSB first.
- RX stop check: sampled mid stop bit.
  - If 1: rx_data loads the shift register, rx_is_completed=1 for exactly one cycle, rx_is_receiving drops, FSM returns to IDLE.
  - If 0 (framing error): rx_data is unchanged, no strobe, FSM waits in IDLE for the line to return high before arming again.
- rx_data holds its value between frames.
- TX and RX are fully independent; simultaneous activity is allowed.

Decomposition:
- Package uart_pkg holds the TX/RX state enum and a DIV-derived counter-width function ($clog2(DIV)).
- uart_link instantiates two sub-modules: uart_tx_core (TX FSM, bit counter, shift register) and uart_rx_core (synchronizer, RX FSM, sampler).
- Each sub-module owns its own baud counter; no shared tick, so RX can re-phase on every start bit.

Test Plan:
All cases use FREQ=100, BAUD=25 (DIV=4), DATA_SIZE=5, with tx_out looped to rx_in unless stated.
- Single frame: 1-cycle tx_start with tx_data=0x0D.
  - tx_out = 0 for 4 cycles, then 1,0,1,1,0 at 4 cycles each, then 1 for 4 cycles; tx_busy high 28 cycles.
  - rx_is_completed pulses once; rx_data=0x0D.
- Second frame after idle: tx_data=0x00 sent 48 cycles after the first.
  - tx_out low for 24 cycles, then stop high; rx_data=0x00 with one strobe.
- tx_start asserted mid-frame with tx_data=0x1F: ignored; line and rx_data show only the original 0x0D.
- Break loopback; drive rx_in low for 1 cycle: rx_is_receiving drops at mid-start check; no strobe; rx_data unchanged.
- Break loopback; drive a frame of 0x15 with stop bit 0: no strobe, rx_data keeps the prior value. Subsequent valid frame 0x0A is received correctly.
- Assert rst mid-frame: tx_out=1, tx_busy=0, rx outputs 0 immediately; a new frame after release completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the uart_link TX/RX cores.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Width of a counter spanning 0..div-1.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Width of a data-bit index spanning 0..n-1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_link_if.sv
// Parallel-side handshake bundle between on-chip logic (master) and uart_link (slave).
interface uart_link_if #(
  parameter int DATA_SIZE = 8
);
  logic                 tx_start;
  logic [DATA_SIZE-1:0] tx_data;
  logic                 tx_busy;
  logic [DATA_SIZE-1:0] rx_data;
  logic                 rx_is_receiving;
  logic                 rx_is_completed;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, rx_data, rx_is_receiving, rx_is_completed
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, rx_data, rx_is_receiving, rx_is_completed
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, framing check on the stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV       = 4,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 receiving_o,
  output logic                 done_o
);

  localparam int CW = cnt_width(DIV);
  localparam int BW = idx_width(DATA_SIZE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_SIZE - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 recv_q, recv_d;
  logic                 done_q, done_d;
  logic                 arm_q, arm_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;

  assign rx_s        = sync2_q;
  assign data_o      = data_q;
  assign receiving_o = recv_q;
  assign done_o      = done_q;

  // Metastability synchronizer on the asynchronous serial input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      recv_q  <= 1'b0;
      done_q  <= 1'b0;
      arm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      recv_q  <= recv_d;
      done_q  <= done_d;
      arm_q   <= arm_d;
    end
  end

  // arm_q blocks a new start after a framing error until the line has gone high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    recv_d  = recv_q;
    done_d  = 1'b0;
    arm_d   = arm_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!arm_q) begin
          arm_d = rx_s;
        end else if (!rx_s) begin
          state_d = ST_START;
          recv_d  = 1'b1;
        end else begin
          recv_d  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            recv_d  = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          shift_d = shift_q >> 1'b1;
          shift_d[DATA_SIZE-1] = rx_s;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          recv_d  = 1'b0;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            arm_d  = 1'b0;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        recv_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_SIZE data bits LSB first, one stop bit, DIV clocks per bit.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DIV       = 4,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int CW = cnt_width(DIV);
  localparam int BW = idx_width(DATA_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_end_s;

  assign bit_end_s = (cnt_q == CNT_LAST);
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; tx_d is the line level for the following bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = ST_START;
          shift_d = data_i;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          tx_d    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1'b1;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1'b1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_link.sv
// UART TX/RX pair; the two cores run independently, each with its own baud counter.
module uart_link
  import uart_pkg::*;
#(
  parameter int FREQ      = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst,
  uart_link_if.slave  bus,
  output logic        tx_out,
  input  logic        rx_in
);

  localparam int DIV = FREQ / BAUD;

  if (DIV < 4) begin : g_div_check
    $error("uart_link: FREQ/BAUD must be at least 4");
  end

  uart_tx_core #(
    .DIV       (DIV),
    .DATA_SIZE (DATA_SIZE)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .start_i (bus.tx_start),
    .data_i  (bus.tx_data),
    .tx_o    (tx_out),
    .busy_o  (bus.tx_busy)
  );

  uart_rx_core #(
    .DIV       (DIV),
    .DATA_SIZE (DATA_SIZE)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_in),
    .data_o      (bus.rx_data),
    .receiving_o (bus.rx_is_receiving),
    .done_o      (bus.rx_is_completed)
  );

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link with DIV=4, DATA_SIZE=5, mostly in loopback.
module tb_uart_link;

  localparam int FREQ = 100;
  localparam int BAUD = 25;
  localparam int DS   = 5;
  localparam int DIV  = 4;
  localparam int FLEN = (DS + 2) * DIV;

  logic clk = 1'b0;
  logic rst;
  logic tx_out;
  logic rx_in;
  logic lb_en;
  logic rx_drv;

  int n_cmp    = 0;
  int n_err    = 0;
  int n_strobe = 0;
  int s_base;
  bit saw_recv;

  uart_link_if #(.DATA_SIZE(DS)) bus();

  uart_link #(
    .FREQ      (FREQ),
    .BAUD      (BAUD),
    .DATA_SIZE (DS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .tx_out (tx_out),
    .rx_in  (rx_in)
  );

  assign rx_in = lb_en ? tx_out : rx_drv;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_is_completed === 1'b1) n_strobe++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_line(input logic [DS-1:0] d, input int k);
    int slot;
    slot = k / DIV;
    if (slot == 0) return 1'b0;
    else if (slot <= DS) return d[slot-1];
    else return 1'b1;
  endfunction

  // Sends one word and checks every cycle of the line; optionally pokes tx_start mid-frame.
  task automatic send_frame(input string tag, input logic [DS-1:0] d, input bit inject);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    for (int k = 0; k < FLEN; k++) begin
      tick();
      if (k == 0) bus.tx_start = 1'b0;
      if (inject && k == 9) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = 5'h1F;
      end
      if (inject && k == 10) bus.tx_start = 1'b0;
      check($sformatf("%s_line%0d", tag, k), 32'(tx_out), 32'(exp_line(d, k)));
      check($sformatf("%s_busy%0d", tag, k), 32'(bus.tx_busy), 32'd1);
    end
    tick();
    check({tag, "_busy_end"}, 32'(bus.tx_busy), 32'd0);
    check({tag, "_idle_line"}, 32'(tx_out), 32'd1);
  endtask

  task automatic drive_frame(input logic [DS-1:0] d, input logic stop_bit);
    rx_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < DS; i++) begin
      rx_drv = d[i];
      tick(DIV);
    end
    rx_drv = stop_bit;
    tick(DIV);
    rx_drv = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    lb_en        = 1'b1;
    rx_drv       = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
    tick(3);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_recv", 32'(bus.rx_is_receiving), 32'd0);
    check("rst_rx_done", 32'(bus.rx_is_completed), 32'd0);
    rst = 1'b0;
    tick(2);

    // Single frame 0x0D in loopback.
    s_base = n_strobe;
    send_frame("f1", 5'h0D, 1'b0);
    tick(8);
    check("f1_strobes", 32'(n_strobe - s_base), 32'd1);
    check("f1_rx_data", 32'(bus.rx_data), 32'h0D);
    check("f1_recv_low", 32'(bus.rx_is_receiving), 32'd0);
    tick(11);

    // All-zero word, accepted 48 cycles after the first.
    s_base = n_strobe;
    send_frame("f2", 5'h00, 1'b0);
    tick(8);
    check("f2_strobes", 32'(n_strobe - s_base), 32'd1);
    check("f2_rx_data", 32'(bus.rx_data), 32'h00);
    tick(11);

    // tx_start with 0x1F while busy must not disturb the 0x0D frame.
    s_base = n_strobe;
    send_frame("f3", 5'h0D, 1'b1);
    tick(8);
    check("f3_strobes", 32'(n_strobe - s_base), 32'd1);
    check("f3_rx_data", 32'(bus.rx_data), 32'h0D);
    check("f3_tx_idle", 32'(bus.tx_busy), 32'd0);

    // One-cycle glitch low: false start.
    lb_en  = 1'b0;
    rx_drv = 1'b1;
    tick(4);
    s_base = n_strobe;
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    saw_recv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rx_is_receiving === 1'b1) saw_recv = 1'b1;
    end
    check("fs_saw_recv", 32'(saw_recv), 32'd1);
    check("fs_recv_low", 32'(bus.rx_is_receiving), 32'd0);
    check("fs_strobes", 32'(n_strobe - s_base), 32'd0);
    check("fs_rx_data", 32'(bus.rx_data), 32'h0D);

    // Framing error on 0x15, then a good 0x0A.
    tick(4);
    s_base = n_strobe;
    drive_frame(5'h15, 1'b0);
    tick(12);
    check("fe_strobes", 32'(n_strobe - s_base), 32'd0);
    check("fe_rx_data", 32'(bus.rx_data), 32'h0D);
    check("fe_recv_low", 32'(bus.rx_is_receiving), 32'd0);
    s_base = n_strobe;
    drive_frame(5'h0A, 1'b1);
    tick(8);
    check("ok_strobes", 32'(n_strobe - s_base), 32'd1);
    check("ok_rx_data", 32'(bus.rx_data), 32'h0A);

    // Asynchronous reset in the middle of a loopback frame.
    lb_en = 1'b1;
    tick(4);
    bus.tx_data  = 5'h0D;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    tick(11);
    check("mr_pre_busy", 32'(bus.tx_busy), 32'd1);
    check("mr_pre_recv", 32'(bus.rx_is_receiving), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_tx_out", 32'(tx_out), 32'd1);
    check("mr_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("mr_rx_data", 32'(bus.rx_data), 32'd0);
    check("mr_rx_recv", 32'(bus.rx_is_receiving), 32'd0);
    check("mr_rx_done", 32'(bus.rx_is_completed), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    s_base = n_strobe;
    send_frame("f4", 5'h0D, 1'b0);
    tick(8);
    check("f4_strobes", 32'(n_strobe - s_base), 32'd1);
    check("f4_rx_data", 32'(bus.rx_data), 32'h0D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
